write_arbiter: RTL and testbench

- Write-side counterpart of the interconnect's read arbitration.
- Arbitrates AW among M masters round-robin and routes each master's address to the decoded slave.
- After each AW, holds the W path to that master/slave pair until the last beat (no write interleaving).
- Arbitrates B responses from S slaves back to the originating master, checked against a per-master, per-ID outstanding tracker.

---
 rtl/write_arbiter_pkg.sv | 25 ++
 rtl/addr_decode.sv | 17 +
 rtl/write_id_tracker.sv | 45 ++++
 rtl/write_arbiter.sv | 166 ++++++++++++++++
 tb/tb_write_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/write_arbiter_pkg.sv
// Shared encodings and width helpers for the write-side arbiter.
package write_arbiter_pkg;

  // AW/W channel sequencer states
  localparam logic [1:0] AW_IDLE  = 2'd0;
  localparam logic [1:0] AWREG    = 2'd1;
  localparam logic [1:0] AW_ALLOW = 2'd2;
  localparam logic [1:0] W_ALLOW  = 2'd3;

  // B channel sequencer states
  localparam logic [1:0] B_IDLE  = 2'd0;
  localparam logic [1:0] B_UNREG = 2'd1;
  localparam logic [1:0] B_ALLOW = 2'd2;

  // Index width for n items, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Number of tracker entries for m masters with n IDs each
  function automatic int entry_count(input int m, input int n);
    return m * n;
  endfunction

endpackage

// File: rtl/addr_decode.sv
// Maps an address onto a slave index: (addr / SLICE_SIZE) mod S.
module addr_decode
  import write_arbiter_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] SLICE_SIZE = 32'h00010000,
  parameter int          S          = 2,
  localparam int         SW         = idx_width(S)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [SW-1:0]         sel
);

  // S is a power of two, so the modulo keeps the low slice-index bits
  assign sel = SW'((addr / ADDR_WIDTH'(SLICE_SIZE)) % ADDR_WIDTH'(S));

endmodule

// File: rtl/write_id_tracker.sv
// Outstanding write tracker: one {valid, slave} entry per master/ID pair.
module write_id_tracker
  import write_arbiter_pkg::*;
#(
  parameter int  M                     = 2,
  parameter int  NUM_OUTSTANDING_TRANS = 2,
  parameter int  SW                    = 1,
  localparam int MW                    = idx_width(M),
  localparam int IDW                   = idx_width(NUM_OUTSTANDING_TRANS),
  localparam int E                     = entry_count(M, NUM_OUTSTANDING_TRANS)
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           set_en,
  input  logic [MW-1:0]  set_master,
  input  logic [IDW-1:0] set_id,
  input  logic [SW-1:0]  set_slave,
  input  logic           clear_en,
  input  logic [MW-1:0]  clear_master,
  input  logic [IDW-1:0] clear_id,
  output logic [E-1:0]   valid,
  output logic [SW-1:0]  slave [E]
);

  logic [MW+IDW-1:0] set_idx;
  logic [MW+IDW-1:0] clear_idx;

  assign set_idx   = {set_master, set_id};
  assign clear_idx = {clear_master, clear_id};

  // Entry update; the set is written last so it wins a same-entry collision
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      valid <= '0;
      for (int e = 0; e < E; e++) slave[e] <= '0;
    end else begin
      if (clear_en) valid[clear_idx] <= 1'b0;
      if (set_en) begin
        valid[set_idx] <= 1'b1;
        slave[set_idx] <= set_slave;
      end
    end
  end

endmodule

// File: rtl/write_arbiter.sv
// Write-side arbiter: round-robin AW with W locked to the AW winner until
// its last beat, and round-robin B responses validated against a tracker.
module write_arbiter
  import write_arbiter_pkg::*;
#(
  parameter int          M                     = 2,
  parameter int          S                     = 2,
  parameter int          NUM_OUTSTANDING_TRANS = 2,
  parameter int          ADDR_WIDTH            = 32,
  parameter logic [31:0] SLICE_SIZE            = 32'h00010000,
  localparam int         MW                    = idx_width(M),
  localparam int         SW                    = idx_width(S),
  localparam int         IDW                   = idx_width(NUM_OUTSTANDING_TRANS),
  localparam int         E                     = entry_count(M, NUM_OUTSTANDING_TRANS)
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [M-1:0]            AW_request_f,
  input  logic [M*ADDR_WIDTH-1:0] AW_addr_f,
  input  logic [M*IDW-1:0]        AW_id_f,
  input  logic [S-1:0]            AW_finish_f,
  output logic [M-1:0]            AW_grant_f,
  output logic [M*SW-1:0]         AW_sel_f,
  input  logic [M-1:0]            W_last_f,
  output logic [M-1:0]            W_grant_f,
  output logic [SW-1:0]           W_sel_f,
  input  logic [S-1:0]            B_request_f,
  input  logic [S*(MW+IDW)-1:0]   B_id_f,
  input  logic [S-1:0]            B_finish_f,
  output logic [S-1:0]            B_grant_f,
  output logic [S*MW-1:0]         B_sel_f
);

  logic [1:0]        aw_state;
  logic [MW-1:0]     aw_sender;
  logic [SW-1:0]     aw_slave;
  logic [1:0]        b_state;
  logic [SW-1:0]     b_sender;
  logic [MW-1:0]     b_master;
  logic [IDW-1:0]    b_tid;

  logic [E-1:0]      trk_valid;
  logic [SW-1:0]     trk_slave [E];

  logic [IDW-1:0]    aw_id_cur;
  logic [SW-1:0]     aw_sel_cur;
  logic [MW+IDW-1:0] aw_idx;
  logic [MW+IDW-1:0] b_id_cur;
  logic              b_hit;

  for (genvar g = 0; g < M; g++) begin : g_dec
    addr_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .SLICE_SIZE (SLICE_SIZE),
      .S          (S)
    ) u_dec (
      .addr (AW_addr_f[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .sel  (AW_sel_f[g*SW +: SW])
    );
  end

  // The routed master is carried in the upper bits of each slave's B ID
  for (genvar j = 0; j < S; j++) begin : g_bsel
    assign B_sel_f[j*MW +: MW] = B_id_f[j*(MW+IDW)+IDW +: MW];
  end

  assign aw_id_cur  = AW_id_f[aw_sender*IDW +: IDW];
  assign aw_sel_cur = AW_sel_f[aw_sender*SW +: SW];
  assign aw_idx     = {aw_sender, aw_id_cur};
  assign b_id_cur   = B_id_f[b_sender*(MW+IDW) +: MW+IDW];
  assign b_hit      = B_request_f[b_sender] && trk_valid[b_id_cur] &&
                      (trk_slave[b_id_cur] == b_sender);

  write_id_tracker #(
    .M                     (M),
    .NUM_OUTSTANDING_TRANS (NUM_OUTSTANDING_TRANS),
    .SW                    (SW)
  ) u_tracker (
    .clk          (clk),
    .clr          (clr),
    .set_en       (aw_state == AWREG),
    .set_master   (aw_sender),
    .set_id       (aw_id_cur),
    .set_slave    (aw_sel_cur),
    .clear_en     (b_state == B_UNREG),
    .clear_master (b_master),
    .clear_id     (b_tid),
    .valid        (trk_valid),
    .slave        (trk_slave)
  );

  // AW/W sequencer: pick a master with a free ID, then hold it through its W burst
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      aw_state  <= AW_IDLE;
      aw_sender <= '0;
      aw_slave  <= '0;
    end else begin
      case (aw_state)
        AW_IDLE: begin
          if (AW_request_f[aw_sender] && !trk_valid[aw_idx]) aw_state <= AWREG;
          else aw_sender <= aw_sender + 1'b1;
        end
        AWREG: begin
          aw_slave <= aw_sel_cur;
          aw_state <= AW_ALLOW;
        end
        AW_ALLOW: begin
          if (AW_finish_f[aw_slave]) aw_state <= W_ALLOW;
        end
        W_ALLOW: begin
          if (W_last_f[aw_sender]) begin
            aw_state  <= AW_IDLE;
            aw_sender <= aw_sender + 1'b1;
          end
        end
        default: aw_state <= AW_IDLE;
      endcase
    end
  end

  // B sequencer: accept only responses that match an outstanding entry from this slave
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      b_state  <= B_IDLE;
      b_sender <= '0;
      b_master <= '0;
      b_tid    <= '0;
    end else begin
      case (b_state)
        B_IDLE: begin
          if (b_hit) begin
            b_state  <= B_UNREG;
            b_master <= b_id_cur[MW+IDW-1:IDW];
            b_tid    <= b_id_cur[IDW-1:0];
          end else begin
            b_sender <= b_sender + 1'b1;
          end
        end
        B_UNREG: b_state <= B_ALLOW;
        B_ALLOW: begin
          if (B_finish_f[b_sender]) begin
            b_state  <= B_IDLE;
            b_sender <= b_sender + 1'b1;
          end
        end
        default: b_state <= B_IDLE;
      endcase
    end
  end

  // Grant decode from the sequencer states; everything else stays low
  always_comb begin
    AW_grant_f = '0;
    W_grant_f  = '0;
    W_sel_f    = '0;
    B_grant_f  = '0;
    if (aw_state == AW_ALLOW) AW_grant_f[aw_sender] = 1'b1;
    if (aw_state == W_ALLOW) begin
      W_grant_f[aw_sender] = 1'b1;
      W_sel_f              = aw_slave;
    end
    if (b_state == B_ALLOW) B_grant_f[b_sender] = 1'b1;
  end

endmodule

// File: tb/tb_write_arbiter.sv
// Scoreboard bench for write_arbiter: expected grants are queued when
// requests are driven and popped when the arbiter grants.
module tb_write_arbiter;

  localparam int          M          = 2;
  localparam int          S          = 2;
  localparam int          NOT        = 2;
  localparam int          ADDR_WIDTH = 32;
  localparam logic [31:0] SLICE      = 32'h00010000;
  localparam int          MW         = 1;
  localparam int          SW         = 1;
  localparam int          IDW        = 1;
  localparam int          BW         = MW + IDW;

  logic                    clk = 1'b0;
  logic                    clr;
  logic [M-1:0]            aw_request;
  logic [M*ADDR_WIDTH-1:0] aw_addr;
  logic [M*IDW-1:0]        aw_id;
  logic [S-1:0]            aw_finish;
  logic [M-1:0]            aw_grant;
  logic [M*SW-1:0]         aw_sel;
  logic [M-1:0]            w_last;
  logic [M-1:0]            w_grant;
  logic [SW-1:0]           w_sel;
  logic [S-1:0]            b_request;
  logic [S*BW-1:0]         b_id;
  logic [S-1:0]            b_finish;
  logic [S-1:0]            b_grant;
  logic [S*MW-1:0]         b_sel;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    int master;
    int slave;
  } exp_t;

  exp_t aw_q[$];
  exp_t b_q[$];

  write_arbiter #(
    .M                     (M),
    .S                     (S),
    .NUM_OUTSTANDING_TRANS (NOT),
    .ADDR_WIDTH            (ADDR_WIDTH),
    .SLICE_SIZE            (SLICE)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .AW_request_f (aw_request),
    .AW_addr_f    (aw_addr),
    .AW_id_f      (aw_id),
    .AW_finish_f  (aw_finish),
    .AW_grant_f   (aw_grant),
    .AW_sel_f     (aw_sel),
    .W_last_f     (w_last),
    .W_grant_f    (w_grant),
    .W_sel_f      (w_sel),
    .B_request_f  (b_request),
    .B_id_f       (b_id),
    .B_finish_f   (b_finish),
    .B_grant_f    (b_grant),
    .B_sel_f      (b_sel)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    clr        = 1'b1;
    aw_request = '0;
    aw_addr    = '0;
    aw_id      = '0;
    aw_finish  = '0;
    w_last     = '0;
    b_request  = '0;
    b_id       = '0;
    b_finish   = '0;
    aw_q.delete();
    b_q.delete();
    #1;
    checkOutput("reset_grants", {aw_grant, w_grant, b_grant}, 0);
    tick();
    tick();
    checkOutput("reset_w_sel", w_sel, 0);
    clr = 1'b0;
  endtask

  task automatic applyStimulus(input int m, input logic [31:0] addr, input int id,
                               input int exp_slave);
    aw_request[m]                     = 1'b1;
    aw_addr[m*ADDR_WIDTH +: ADDR_WIDTH] = addr;
    aw_id[m*IDW +: IDW]               = IDW'(id);
    aw_q.push_back('{m, exp_slave});
  endtask

  task automatic applyB(input int s, input int m, input int id, input bit expect_grant);
    b_request[s]        = 1'b1;
    b_id[s*BW +: BW]    = {MW'(m), IDW'(id)};
    if (expect_grant) b_q.push_back('{m, s});
  endtask

  task automatic waitAwGrant(input int budget, output int lat, output int m, output int s);
    exp_t e;
    lat = 0;
    while (aw_grant == '0 && lat < budget) begin
      tick();
      lat++;
    end
    if (aw_q.size() == 0) begin
      checkOutput("aw_sb_empty", 1, 0);
      m = 0;
      s = 0;
      return;
    end
    e = aw_q.pop_front();
    m = e.master;
    s = e.slave;
    checkOutput("aw_grant", aw_grant, 64'd1 << m);
    checkOutput("aw_sel", aw_sel[m*SW +: SW], s);
  endtask

  task automatic waitBGrant(input int budget, output int lat, output int m, output int s);
    exp_t e;
    lat = 0;
    while (b_grant == '0 && lat < budget) begin
      tick();
      lat++;
    end
    if (b_q.size() == 0) begin
      checkOutput("b_sb_empty", 1, 0);
      m = 0;
      s = 0;
      return;
    end
    e = b_q.pop_front();
    m = e.master;
    s = e.slave;
    checkOutput("b_grant", b_grant, 64'd1 << s);
    checkOutput("b_sel", b_sel[s*MW +: MW], m);
  endtask

  task automatic completeAw(input int m, input int s);
    aw_finish[s]  = 1'b1;
    aw_request[m] = 1'b0;
    tick();
    aw_finish = '0;
    checkOutput("w_grant", w_grant, 64'd1 << m);
    checkOutput("w_sel", w_sel, s);
    checkOutput("aw_grant_drop", aw_grant, 0);
    w_last[m] = 1'b1;
    tick();
    w_last = '0;
    checkOutput("w_grant_drop", w_grant, 0);
  endtask

  task automatic completeB(input int s);
    b_finish[s]  = 1'b1;
    b_request[s] = 1'b0;
    tick();
    b_finish = '0;
    checkOutput("b_grant_drop", b_grant, 0);
  endtask

  task automatic expectNoAw(input string tag, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      tick();
      seen |= |aw_grant;
    end
    checkOutput(tag, seen, 0);
  endtask

  task automatic expectNoB(input string tag, input int s, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      tick();
      seen |= b_grant[s];
    end
    checkOutput(tag, seen, 0);
  endtask

  // Grants must be one-hot or zero on every cycle
  always @(negedge clk) begin
    checkOutput("grant_onehot",
                $onehot0(aw_grant) && $onehot0(w_grant) && $onehot0(b_grant), 1);
  end

  // Hard stop in case the sequence stalls somewhere unexpected
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected sequence end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, m, s;

    doReset();

    $display("[TB] basic AW/W to slave 1");
    applyStimulus(0, 32'h0001_0004, 0, 1);
    waitAwGrant(20, lat, m, s);
    checkOutput("aw_latency", lat, 2);
    completeAw(m, s);

    $display("[TB] duplicate ID blocked until B clears it");
    applyStimulus(0, 32'h0001_0004, 0, 1);
    expectNoAw("aw_dup_blocked", 8);
    applyB(1, 0, 0, 1'b1);
    waitBGrant(20, lat, m, s);
    checkOutput("b_latency", (lat == 2) || (lat == 3), 1);
    completeB(s);
    waitAwGrant(20, lat, m, s);
    completeAw(m, s);

    $display("[TB] mismatched slave response skipped");
    applyB(0, 0, 0, 1'b0);
    expectNoB("b_mismatch_blocked", 0, 8);
    applyB(1, 0, 0, 1'b1);
    waitBGrant(20, lat, m, s);
    completeB(s);
    expectNoB("b_stale_blocked", 0, 6);
    b_request = '0;

    $display("[TB] round robin between two masters");
    doReset();
    applyStimulus(0, 32'h0000_0010, 0, 0);
    applyStimulus(1, 32'h0001_0000, 0, 1);
    waitAwGrant(20, lat, m, s);
    checkOutput("rr_latency0", lat, 2);
    completeAw(m, s);
    applyStimulus(0, 32'h0002_0000, 1, 0);
    waitAwGrant(20, lat, m, s);
    checkOutput("rr_latency1", lat, 2);
    completeAw(m, s);
    waitAwGrant(20, lat, m, s);
    checkOutput("rr_latency2", lat, 2);
    completeAw(m, s);

    $display("[TB] async clear during W burst");
    doReset();
    applyStimulus(0, 32'h0000_0000, 0, 0);
    waitAwGrant(20, lat, m, s);
    aw_finish[0]  = 1'b1;
    aw_request[0] = 1'b0;
    tick();
    aw_finish = '0;
    checkOutput("w_before_clr", w_grant, 1);
    clr = 1'b1;
    #1;
    checkOutput("async_clr_w", {aw_grant, w_grant, b_grant}, 0);
    doReset();
    applyStimulus(0, 32'h0001_0000, 0, 1);
    waitAwGrant(20, lat, m, s);
    checkOutput("aw_after_clr_latency", lat, 2);
    completeAw(m, s);

    $display("[TB] async clear during B response");
    applyStimulus(1, 32'h0001_0000, 0, 1);
    waitAwGrant(20, lat, m, s);
    completeAw(m, s);
    applyB(1, 0, 0, 1'b1);
    waitBGrant(20, lat, m, s);
    clr = 1'b1;
    #1;
    checkOutput("async_clr_b", {aw_grant, w_grant, b_grant}, 0);
    doReset();
    applyB(1, 1, 0, 1'b0);
    expectNoB("b_after_clr", 1, 8);
    b_request = '0;

    $display("[TB] address wrap decode");
    applyStimulus(1, 32'h0003_0000, 1, 1);
    waitAwGrant(20, lat, m, s);
    completeAw(m, s);
    applyB(1, 1, 1, 1'b1);
    waitBGrant(20, lat, m, s);
    completeB(s);
    applyStimulus(1, 32'h0003_0000, 1, 1);
    waitAwGrant(20, lat, m, s);
    completeAw(m, s);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
